// File: rtl/spm_seq_ctrl.sv
// rtl/spm_seq_ctrl.sv - operand sequencer for the serial-parallel multiplier; SPM_SEQ_CTRL_OPCNT_EN adds a completed-op counter
module spm_seq_ctrl #(
    parameter int W       = 16,
    parameter int SPM_LAT = 1,
    parameter bit SIGNED  = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           op_valid_i,
    output logic           op_ready_o,
    input  logic [W-1:0]   op_x_i,
    input  logic [W-1:0]   op_y_i,
    output logic           res_valid_o,
    input  logic           res_ready_i,
    output logic [2*W-1:0] res_p_o,
    output logic           busy_o,
    output logic           spm_rst_o,
    output logic [W-1:0]   spm_x_o,
    output logic           spm_y_o,
`ifdef SPM_SEQ_CTRL_OPCNT_EN
    input  logic           opcnt_clr_i,
    output logic [15:0]    ops_done_o,
`endif
    input  logic           spm_p_i
);

    localparam int N  = 2 * W;
    localparam int CW = $clog2(N + SPM_LAT + 1);
    localparam logic [CW-1:0] CNT_LAT  = CW'(SPM_LAT);
    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N + SPM_LAT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d, y_q, y_d;
    logic [N-1:0]   res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           op_ready_q, op_ready_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           spm_rst_q, spm_rst_d;
    logic           spm_y_q, spm_y_d;
    logic [N-1:0]   yext, yext_sh;

    assign yext = SIGNED ? {{W{y_q[W-1]}}, y_q} : {{W{1'b0}}, y_q};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        yext_sh = '0;
        case (state_q)
            IDLE: begin
                if (op_valid_i && op_ready_q) begin
                    x_d     = op_x_i;
                    y_d     = op_y_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                // product bit k arrives SPM_LAT cycles after y bit k was driven
                if (cnt_q >= CNT_LAT) begin
                    res_d = {spm_p_i, res_q[N-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // outputs are registered, so decode them from the next state
        op_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
        spm_rst_d   = (state_d != SHIFT);
        yext_sh     = yext >> cnt_d;
        spm_y_d     = (state_d == SHIFT) && (cnt_d < CNT_N) && yext_sh[0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            spm_rst_q   <= 1'b1;
            spm_y_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            cnt_q       <= cnt_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            spm_rst_q   <= spm_rst_d;
            spm_y_q     <= spm_y_d;
        end
    end

    assign op_ready_o  = op_ready_q;
    assign res_valid_o = res_valid_q;
    assign res_p_o     = res_q;
    assign busy_o      = busy_q;
    assign spm_rst_o   = spm_rst_q;
    assign spm_x_o     = x_q;
    assign spm_y_o     = spm_y_q;

`ifdef SPM_SEQ_CTRL_OPCNT_EN
    logic [15:0] opcnt_q, opcnt_d;

    always_comb begin
        opcnt_d = opcnt_q;
        if (opcnt_clr_i) begin
            opcnt_d = '0;
        end else if (res_valid_q && res_ready_i && (opcnt_q != 16'hFFFF)) begin
            opcnt_d = opcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            opcnt_q <= '0;
        end else begin
            opcnt_q <= opcnt_d;
        end
    end

    assign ops_done_o = opcnt_q;
`endif

endmodule
